dsp48a1_mac_seq: RTL

Streaming multiply-accumulate sequencer that acts as the initiator driving a DSP48A1 slice. It accepts (a, b) term pairs on a valid/ready stream and issues them to the slice with the correct per-term opmode (first term restarts the accumulator, later terms accumulate into P). It tracks the slice pipeline latency with a tag delay line and returns one dot-product result per vector on a valid/ready result port. Backpressure freezes the whole slice pipeline through its clock enables.

---
 rtl/dsp48a1_pkg.sv | 34 +++
 rtl/dsp48a1_mac_seq_if.sv | 24 ++
 rtl/dsp48a1_tag_pipe.sv | 31 +++
 rtl/dsp48a1_mac_seq.sv | 113 +++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared constants, tag type and opmode helper for the DSP48A1 MAC sequencer.
package dsp48a1_pkg;

  localparam int unsigned LAT_DEF     = 3;
  localparam int unsigned OPM_DLY_DEF = 1;

  // Z=0, X=M: restart the accumulator with this product.
  localparam logic [7:0] OPM_FIRST   = 8'h01;
  // Z=P, X=M: accumulate this product into P.
  localparam logic [7:0] OPM_ACC     = 8'h09;
  // Z=P, X=0: P holds through a bubble.
  localparam logic [7:0] OPM_HOLD    = 8'h08;
  localparam int unsigned OPM_SUB_BIT = 7;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic sub;
  } tag_t;

  // Pre-adder, carry-in and B source bits [6:4] always stay zero.
  function automatic logic [7:0] tag_opmode(input tag_t t);
    logic [7:0] op;
    if (!t.valid) begin
      op = OPM_HOLD;
    end else begin
      op = t.first ? OPM_FIRST : OPM_ACC;
      op[OPM_SUB_BIT] = t.sub;
    end
    return op;
  endfunction

endpackage

// File: rtl/dsp48a1_mac_seq_if.sv
// Term input stream and result output stream of the MAC sequencer.
interface dsp48a1_mac_seq_if;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic        s_sub;
  logic        s_last;
  logic        r_valid;
  logic        r_ready;
  logic [47:0] r_data;
  logic        r_cout;
  logic [15:0] r_terms;

  modport master (
    output s_valid, s_a, s_b, s_sub, s_last, r_ready,
    input  s_ready, r_valid, r_data, r_cout, r_terms
  );

  modport slave (
    input  s_valid, s_a, s_b, s_sub, s_last, r_ready,
    output s_ready, r_valid, r_data, r_cout, r_terms
  );
endinterface

// File: rtl/dsp48a1_tag_pipe.sv
// Tag delay line that shadows the slice pipeline; LAT must be at least 2.
module dsp48a1_tag_pipe
  import dsp48a1_pkg::*;
#(
  parameter int unsigned LAT     = LAT_DEF,
  parameter int unsigned OPM_DLY = OPM_DLY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  tag_t tag_in,
  output tag_t tap,
  output tag_t tag_out
);

  // stage[k] holds the tag of the slot whose operands were driven k cycles ago.
  tag_t [LAT:1] stage;

  // Shift only when the slice clock enables are active so tags stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else if (en) begin
      stage <= {stage[LAT-1:1], tag_in};
    end
  end

  assign tap     = stage[OPM_DLY];
  assign tag_out = stage[LAT];

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// Streaming MAC sequencer driving a DSP48A1 slice, one result per vector.
module dsp48a1_mac_seq
  import dsp48a1_pkg::*;
#(
  parameter int unsigned LAT     = LAT_DEF,
  parameter int unsigned OPM_DLY = OPM_DLY_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  dsp48a1_mac_seq_if.slave        bus,
  output logic [17:0]             dsp_a,
  output logic [17:0]             dsp_b,
  output logic [7:0]              dsp_opmode,
  output logic                    dsp_ce,
  output logic                    dsp_rst,
  input  logic [47:0]             dsp_p,
  input  logic                    dsp_carryout
);

  logic stall;
  logic ce;
  logic accept;
  logic load;
  logic first_pending;
  logic [15:0] term_cnt;
  logic [15:0] cnt_inc;
  tag_t tag_in;
  tag_t tap;
  tag_t tag_out;
  logic [LAT:1][15:0] terms_line;
  logic unused_tag_bits;

  assign stall      = bus.r_valid && !bus.r_ready;
  assign ce         = !stall && !rst;
  assign bus.s_ready = ce;
  assign accept     = bus.s_valid && ce;
  assign dsp_ce     = ce;
  assign dsp_rst    = rst;

  // Operands go straight to the slice A1/B1 registers; bubbles issue zeros.
  assign dsp_a = accept ? bus.s_a : '0;
  assign dsp_b = accept ? bus.s_b : '0;

  assign cnt_inc = (term_cnt == '1) ? term_cnt : term_cnt + 16'd1;

  // Slot tag for this cycle's operands.
  always_comb begin
    tag_in = '0;
    if (accept) begin
      tag_in.valid = 1'b1;
      tag_in.first = first_pending;
      tag_in.last  = bus.s_last;
      tag_in.sub   = bus.s_sub;
    end
  end

  dsp48a1_tag_pipe #(
    .LAT     (LAT),
    .OPM_DLY (OPM_DLY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (ce),
    .tag_in  (tag_in),
    .tap     (tap),
    .tag_out (tag_out)
  );

  assign unused_tag_bits = &{1'b0, tag_out.first, tag_out.sub, tap.last};

  // Opmode follows its operands by OPM_DLY slots via the tag tap.
  assign dsp_opmode = rst ? '0 : tag_opmode(tap);

  // Term counting and first-term tracking across vector boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      term_cnt      <= '0;
      first_pending <= 1'b1;
    end else if (accept) begin
      term_cnt      <= bus.s_last ? '0 : cnt_inc;
      first_pending <= bus.s_last;
    end
  end

  // Vector term count rides alongside the tags so it reaches the result with P.
  always_ff @(posedge clk) begin
    if (rst) begin
      terms_line <= '0;
    end else if (ce) begin
      terms_line <= {terms_line[LAT-1:1], (accept && bus.s_last) ? cnt_inc : 16'd0};
    end
  end

  assign load = ce && tag_out.valid && tag_out.last;

  // Result holding register; a new load takes priority over consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r_valid <= 1'b0;
      bus.r_data  <= '0;
      bus.r_cout  <= 1'b0;
      bus.r_terms <= '0;
    end else if (load) begin
      bus.r_valid <= 1'b1;
      bus.r_data  <= dsp_p;
      bus.r_cout  <= dsp_carryout;
      bus.r_terms <= terms_line[LAT];
    end else if (bus.r_ready) begin
      bus.r_valid <= 1'b0;
    end
  end

endmodule
